clk_div_cfg_ctrl: RTL and testbench
===================================

# clk_div_cfg_ctrl

Configuration initiator for a runtime-programmable integer clock divider. It accepts divide-ratio writes from a register/control interface and drives the divider's `div`/`div_valid`/`div_ready` handshake. It holds one pending value, supports an optional timeout, and tracks the last ratio the divider accepted. It sits in the clock/reset subsystem between the CSR block and the divider instance.

## Interface
- `DIV_WIDTH`, default 8: width of the divide ratio.
- `RESET_DIV`, default 2: value of `cur_div_o` after reset; also the value auto-issued when `INIT_ON_RESET` = 1.
- `INIT_ON_RESET`, default 1'b0: 1 issues `RESET_DIV` automatically once after reset.
- `TIMEOUT_CYCLES`, default 0: maximum REQ cycles without handshake. 0 disables the timeout.

Ports:
- `clk_i` in 1: clock. One clock domain only.
- `rst_n_i` in 1: reset, asynchronous assert, active-low.
- `cfg_wr_i` in 1: single-cycle write strobe.
- `cfg_div_i` in DIV_WIDTH: ratio to program, sampled when `cfg_wr_i` = 1.
- `cfg_busy_o` out 1: high while in REQ or while a pending value is held.
- `cfg_done_o` out 1: one-cycle pulse, asserted the cycle after each handshake.
- `cfg_err_o` out 1: one-cycle pulse, asserted the cycle after a write of zero is rejected.
- `cfg_timeout_o` out 1: one-cycle pulse, asserted the cycle after a timeout.
- `div_o` out DIV_WIDTH: ratio offered to the divider.
- `div_valid_o` out 1: request valid.
- `div_ready_i` in 1: divider accepts.
- `cur_div_o` out DIV_WIDTH: last ratio accepted by the divider.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - `div_valid_o` = 0, `div_o` = 0.
  - `cur_div_o` = RESET_DIV.
  - `cfg_done_o`, `cfg_err_o`, `cfg_timeout_o`, `cfg_busy_o` = 0.
  - pending flag = 0.
  - timeout counter = 0.
- States are IDLE and REQ. With `INIT_ON_RESET` = 1, the first clock after reset release enters REQ with `div_o` = RESET_DIV.
- A write of zero (`cfg_wr_i` & `cfg_div_i` == 0) is ignored in every state and pulses `cfg_err_o`. It does not disturb pending or REQ.
- IDLE, nonzero write: go to REQ, `div_o` ← `cfg_div_i`, `div_valid_o` ← 1, counter ← 0.
- REQ behaviour:
  - `div_valid_o` stays high and `div_o` stays stable until handshake or timeout. Never drop valid otherwise.
  - A nonzero write loads the pending register. A later write overwrites an older pending value (last-write-wins).
- Handshake = `div_valid_o` & `div_ready_i` at a rising edge. On handshake:
  - `cur_div_o` ← `div_o`.
  - `cfg_done_o` pulses.
  - If pending is held: stay in REQ, `div_o` ← pending, clear pending, counter ← 0. Valid stays high with no gap.
  - Else if a write arrives in the same cycle: treat it as pending, so it is issued back-to-back.
  - Else: go to IDLE, `div_valid_o` ← 0.
- Timeout (TIMEOUT_CYCLES > 0): the counter increments every REQ cycle without handshake. When counter == TIMEOUT_CYCLES-1 and no handshake:
  - `div_valid_o` ← 0, `cfg_timeout_o` pulses.
  - The pending value is discarded.
  - `cur_div_o` is unchanged. Go to IDLE.
  - If a nonzero write coincides with the timeout, it starts a fresh REQ in the next cycle (valid stays high with new `div_o`, counter ← 0).
- A handshake in the same cycle as the timeout threshold counts as a handshake; no timeout occurs.
- The counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter saturates and never wraps.
- `cfg_busy_o` = (next state == REQ) | next pending. It is registered and aligned with `div_valid_o`.
- Reset mid-REQ clears everything immediately. Outputs return to their reset values asynchronously.

## Timing
- Write at edge n (IDLE) → `div_valid_o`/`div_o` valid after edge n, visible in cycle n+1.
- Handshake at edge m → `cfg_done_o` high and `cur_div_o` updated in cycle m+1. `div_valid_o` low in cycle m+1 unless pending.
- Minimum write-to-accept latency: 1 cycle when `div_ready_i` is held high. Maximum sustained rate: one handshake per cycle while pending is refilled every cycle.
- Timeout: `div_valid_o` is high for exactly TIMEOUT_CYCLES cycles, then low. `cfg_timeout_o` is high in the first low cycle.

## Test plan
- Reset with RESET_DIV=4, INIT_ON_RESET=0 → all outputs 0, `cur_div_o`=4. Then write 6 with `div_ready_i`=1 → valid high 1 cycle, `div_o`=6, `cfg_done_o` pulse, `cur_div_o`=6.
- `div_ready_i`=0; write 8, then write 10 and 12 during REQ, then raise ready → two handshakes (8, then 12 back-to-back, valid never drops). `cur_div_o`=12. The value 10 is never presented.
- Write 0 in IDLE and in REQ → `cfg_err_o` pulse each time. `div_o`, state and pending are unchanged.
- TIMEOUT_CYCLES=5, ready tied 0, write 6, plus pending 8 → valid high exactly 5 cycles, then `cfg_timeout_o` pulse. The pending value is discarded and `cur_div_o` keeps its old value.
- INIT_ON_RESET=1, RESET_DIV=2 → after reset release, `div_valid_o`=1 with `div_o`=2. Ready → `cfg_done_o` pulse.
- Assert `rst_n_i` low mid-REQ with pending held → `div_valid_o`=0 immediately (asynchronous). `cur_div_o`=RESET_DIV and pending cleared.

Source files
------------

// File: rtl/clk_div_cfg_ctrl.sv
// rtl/clk_div_cfg_ctrl.sv - configuration initiator for a runtime-programmable clock divider
//
// Accepts divide-ratio writes and drives the divider's valid/ready handshake.
// Holds one pending ratio (last write wins), optionally times out a stalled
// request, and tracks the last ratio the divider accepted.
//
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   cfg_wr_i          write strobe; cfg_div_i is the ratio sampled with it
//   cfg_busy_o        request outstanding or pending ratio held
//   cfg_done_o        pulse, cycle after a handshake
//   cfg_err_o         pulse, cycle after a rejected zero write
//   cfg_timeout_o     pulse, cycle after a timeout
//   div_o/div_valid_o ratio and valid offered to the divider
//   div_ready_i       divider accepts
//   cur_div_o         last ratio accepted by the divider
module clk_div_cfg_ctrl #(
  parameter int DIV_WIDTH      = 8,
  parameter int RESET_DIV      = 2,
  parameter bit INIT_ON_RESET  = 1'b0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cfg_wr_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  output logic                 cfg_busy_o,
  output logic                 cfg_done_o,
  output logic                 cfg_err_o,
  output logic                 cfg_timeout_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 div_valid_o,
  input  logic                 div_ready_i,
  output logic [DIV_WIDTH-1:0] cur_div_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Threshold and saturation value; both collapse to 0 when the timeout is off,
  // which freezes the counter at 0.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0);
  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);

  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_init_done;
  logic                 r_pend;
  logic [DIV_WIDTH-1:0] r_pend_div;
  logic [CNT_W-1:0]     r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_valid;
  logic [DIV_WIDTH-1:0] r_cur;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic                 r_to;

  logic                 w_pend_nxt;
  logic [DIV_WIDTH-1:0] w_pend_div_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic [DIV_WIDTH-1:0] w_cur_nxt;
  logic                 w_done_nxt;
  logic                 w_to_nxt;

  logic                 w_wr_ok;
  logic                 w_wr_zero;
  logic                 w_hs;
  logic                 w_timeout;
  logic                 w_init;
  logic [CNT_W-1:0]     w_cnt_inc;

  assign w_wr_ok   = cfg_wr_i & (cfg_div_i != '0);
  assign w_wr_zero = cfg_wr_i & (cfg_div_i == '0);
  assign w_hs      = (r_state == ST_REQ) & r_valid & div_ready_i;
  // A handshake at the threshold wins over the timeout.
  assign w_timeout = (TIMEOUT_CYCLES > 0) & (r_state == ST_REQ) & ~w_hs &
                     (r_cnt == CNT_LAST);
  // One-shot auto-issue of RESET_DIV on the first clock after reset release.
  assign w_init    = INIT_ON_RESET & ~r_init_done;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_init) begin
      w_state_nxt = ST_REQ;
    end else begin
      case (r_state)
        ST_IDLE: if (w_wr_ok) w_state_nxt = ST_REQ;
        ST_REQ: begin
          if (w_hs) begin
            w_state_nxt = (r_pend | w_wr_ok) ? ST_REQ : ST_IDLE;
          end else if (w_timeout) begin
            w_state_nxt = w_wr_ok ? ST_REQ : ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    w_pend_nxt     = r_pend;
    w_pend_div_nxt = r_pend_div;
    w_cnt_nxt      = r_cnt;
    w_div_nxt      = r_div;
    w_cur_nxt      = r_cur;
    w_done_nxt     = 1'b0;
    w_to_nxt       = 1'b0;
    if (w_init) begin
      w_div_nxt = RST_DIV;
      w_cnt_nxt = '0;
      if (w_wr_ok) begin
        w_pend_nxt     = 1'b1;
        w_pend_div_nxt = cfg_div_i;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_ok) begin
            w_div_nxt = cfg_div_i;
            w_cnt_nxt = '0;
          end
        end
        ST_REQ: begin
          if (w_hs) begin
            w_cur_nxt  = r_div;
            w_done_nxt = 1'b1;
            if (r_pend) begin
              // Issue the held ratio back-to-back; a same-cycle write refills pending.
              w_div_nxt      = r_pend_div;
              w_cnt_nxt      = '0;
              w_pend_nxt     = w_wr_ok;
              w_pend_div_nxt = w_wr_ok ? cfg_div_i : r_pend_div;
            end else if (w_wr_ok) begin
              w_div_nxt = cfg_div_i;
              w_cnt_nxt = '0;
            end
          end else if (w_timeout) begin
            w_to_nxt   = 1'b1;
            w_pend_nxt = 1'b0;
            w_cnt_nxt  = '0;
            if (w_wr_ok) w_div_nxt = cfg_div_i;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_wr_ok) begin
              w_pend_nxt     = 1'b1;
              w_pend_div_nxt = cfg_div_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_init_done <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_div  <= '0;
      r_cnt       <= '0;
      r_div       <= '0;
      r_valid     <= 1'b0;
      r_cur       <= RST_DIV;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_to        <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
      r_pend      <= w_pend_nxt;
      r_pend_div  <= w_pend_div_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div       <= w_div_nxt;
      r_valid     <= (w_state_nxt == ST_REQ);
      r_cur       <= w_cur_nxt;
      r_busy      <= (w_state_nxt == ST_REQ) | w_pend_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_wr_zero;
      r_to        <= w_to_nxt;
    end
  end

  assign div_o         = r_div;
  assign div_valid_o   = r_valid;
  assign cur_div_o     = r_cur;
  assign cfg_busy_o    = r_busy;
  assign cfg_done_o    = r_done;
  assign cfg_err_o     = r_err;
  assign cfg_timeout_o = r_to;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// tb/tb_clk_div_cfg_ctrl.sv - self-checking bench for clk_div_cfg_ctrl
module tb_clk_div_cfg_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RESET_DIV=4, no auto-issue, timeout 5
  logic       rst_a, a_wr, a_rdy;
  logic [7:0] a_din;
  logic       a_busy, a_done, a_err, a_to, a_valid;
  logic [7:0] a_div, a_cur;

  // Instance B: RESET_DIV=2, auto-issue after reset, no timeout
  logic       rst_b, b_wr, b_rdy;
  logic [7:0] b_din;
  logic       b_busy, b_done, b_err, b_to, b_valid;
  logic [7:0] b_div, b_cur;

  clk_div_cfg_ctrl #(.DIV_WIDTH(8), .RESET_DIV(4), .INIT_ON_RESET(1'b0), .TIMEOUT_CYCLES(5)) dut_a (
    .clk_i(clk), .rst_n_i(rst_a), .cfg_wr_i(a_wr), .cfg_div_i(a_din),
    .cfg_busy_o(a_busy), .cfg_done_o(a_done), .cfg_err_o(a_err), .cfg_timeout_o(a_to),
    .div_o(a_div), .div_valid_o(a_valid), .div_ready_i(a_rdy), .cur_div_o(a_cur)
  );

  clk_div_cfg_ctrl #(.DIV_WIDTH(8), .RESET_DIV(2), .INIT_ON_RESET(1'b1), .TIMEOUT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_b), .cfg_wr_i(b_wr), .cfg_div_i(b_din),
    .cfg_busy_o(b_busy), .cfg_done_o(b_done), .cfg_err_o(b_err), .cfg_timeout_o(b_to),
    .div_o(b_div), .div_valid_o(b_valid), .div_ready_i(b_rdy), .cur_div_o(b_cur)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int high;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set: a handshake about to happen
  // on instance A must present the oldest expected ratio.
  task automatic step();
    int e;
    if (a_valid && a_rdy) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD;
      chk("hs_div", {24'd0, a_div}, e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b0; a_wr = 1'b0; a_din = '0; a_rdy = 1'b0;
    rst_b = 1'b0; b_wr = 1'b0; b_din = '0; b_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_valid", a_valid, 0);
    chk("rst_div", a_div, 0);
    chk("rst_cur", a_cur, 4);
    chk("rst_busy", a_busy, 0);
    chk("rst_flags", {a_done, a_err, a_to}, 0);
    chk("rst_b_cur", b_cur, 2);
    chk("rst_b_valid", b_valid, 0);
    rst_a = 1'b1;
    step();

    // Single write with ready held high
    a_rdy = 1'b1; a_wr = 1'b1; a_din = 8'd6; exp_q.push_back(6);
    step();
    a_wr = 1'b0;
    chk("t1_valid", a_valid, 1);
    chk("t1_div", a_div, 6);
    chk("t1_busy", a_busy, 1);
    step();
    chk("t1_done", a_done, 1);
    chk("t1_cur", a_cur, 6);
    chk("t1_valid_low", a_valid, 0);
    chk("t1_busy_low", a_busy, 0);
    step();
    chk("t1_done_low", a_done, 0);

    // Pending last-write-wins, back-to-back issue
    a_rdy = 1'b0; a_wr = 1'b1; a_din = 8'd8; exp_q.push_back(8);
    step();
    a_din = 8'd10;
    step();
    a_din = 8'd12; exp_q.push_back(12);
    step();
    a_wr = 1'b0; a_rdy = 1'b1;
    chk("t2_div_held", a_div, 8);
    step();
    chk("t2_done1", a_done, 1);
    chk("t2_cur1", a_cur, 8);
    chk("t2_valid_kept", a_valid, 1);
    chk("t2_div2", a_div, 12);
    step();
    chk("t2_done2", a_done, 1);
    chk("t2_cur2", a_cur, 12);
    chk("t2_valid_low", a_valid, 0);

    // Zero write in IDLE
    a_rdy = 1'b0; a_wr = 1'b1; a_din = 8'd0;
    step();
    a_wr = 1'b0;
    chk("t3_err_idle", a_err, 1);
    chk("t3_idle_valid", a_valid, 0);
    chk("t3_idle_div", a_div, 12);
    chk("t3_idle_busy", a_busy, 0);
    step();
    chk("t3_err_low", a_err, 0);

    // Zero write in REQ with a pending value held
    a_wr = 1'b1; a_din = 8'd14; exp_q.push_back(14);
    step();
    a_din = 8'd5; exp_q.push_back(5);
    step();
    a_din = 8'd0;
    step();
    a_wr = 1'b0;
    chk("t3_err_req", a_err, 1);
    chk("t3_req_div", a_div, 14);
    chk("t3_req_valid", a_valid, 1);
    chk("t3_req_busy", a_busy, 1);
    a_rdy = 1'b1;
    step();
    chk("t3_pend_kept", a_div, 5);
    step();
    chk("t3_cur", a_cur, 5);
    chk("t3_valid_low", a_valid, 0);

    // Timeout: valid high exactly 5 cycles, pending discarded
    a_rdy = 1'b0; a_wr = 1'b1; a_din = 8'd6;
    step();
    high = 0;
    for (int i = 0; i < 12; i++) begin
      if (!a_valid) break;
      high++;
      a_wr = (i == 0); a_din = 8'd8;
      step();
    end
    a_wr = 1'b0;
    chk("t4_high_cycles", high, 5);
    chk("t4_timeout", a_to, 1);
    chk("t4_valid_low", a_valid, 0);
    chk("t4_busy_low", a_busy, 0);
    chk("t4_cur_kept", a_cur, 5);
    a_rdy = 1'b1;
    step();
    chk("t4_timeout_low", a_to, 0);
    chk("t4_pend_dropped", a_valid, 0);

    // Write coinciding with timeout starts a fresh request
    a_rdy = 1'b0; a_wr = 1'b1; a_din = 8'd9;
    step();
    a_wr = 1'b0;
    repeat (4) step();
    a_wr = 1'b1; a_din = 8'd11;
    step();
    a_wr = 1'b0;
    chk("t4b_timeout", a_to, 1);
    chk("t4b_valid", a_valid, 1);
    chk("t4b_div", a_div, 11);
    a_rdy = 1'b1; exp_q.push_back(11);
    step();
    chk("t4b_done", a_done, 1);
    chk("t4b_cur", a_cur, 11);
    a_rdy = 1'b0;
    step();

    // Asynchronous reset mid-REQ with pending held
    a_wr = 1'b1; a_din = 8'd7;
    step();
    a_din = 8'd3;
    step();
    a_wr = 1'b0;
    chk("t5_pre_valid", a_valid, 1);
    #2 rst_a = 1'b0;
    #1;
    chk("t5_async_valid", a_valid, 0);
    chk("t5_async_cur", a_cur, 4);
    chk("t5_async_busy", a_busy, 0);
    chk("t5_async_div", a_div, 0);
    @(negedge clk);
    rst_a = 1'b1;
    step();
    chk("t5_post_valid", a_valid, 0);
    chk("t5_post_busy", a_busy, 0);

    // Auto-issue of RESET_DIV after reset release
    rst_b = 1'b1;
    step();
    chk("t6_valid", b_valid, 1);
    chk("t6_div", b_div, 2);
    chk("t6_busy", b_busy, 1);
    step();
    step();
    chk("t6_no_timeout", b_valid, 1);
    b_rdy = 1'b1;
    step();
    chk("t6_done", b_done, 1);
    chk("t6_cur", b_cur, 2);
    chk("t6_valid_low", b_valid, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
